// File: rtl/pwm_multi.sv
`timescale 1ns/100ps
// pwm_multi
// Multi-channel PWM generator. All channels share one free-running counter
// that runs either edge-aligned (sawtooth 0..period) or center-aligned
// (triangle 0..period..1). Each channel has a shadow compare register that
// software writes at any time. The shadow values are copied into the active
// compare registers only at a cycle boundary, so an output never changes its
// settings partway through a PWM cycle.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       run the counter; low holds the counter at 0 and pwm at 0
//   center       0 = edge-aligned, 1 = center-aligned (taken at a boundary)
//   period       counter top value (taken at a boundary)
//   wr_en        write strobe for a shadow compare register
//   wr_ch        channel index of the write (out-of-range index is ignored)
//   wr_compare   compare value to write
//   pwm          registered PWM outputs, bit i = channel i
//   cycle_start  one-clock pulse, aligned with the first output of a new cycle
module pwm_multi #(
    parameter int CTR_LEN  = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                center,
    input  logic [CTR_LEN-1:0]  period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CTR_LEN-1:0]  wr_compare,
    output logic [CHANNELS-1:0] pwm,
    output logic                cycle_start
);

    logic [CTR_LEN-1:0]  cnt_reg, cnt_next;
    logic                dir_down_reg, dir_down_next;
    logic [CTR_LEN-1:0]  act_period_reg;
    logic                act_center_reg;
    logic [CHANNELS-1:0] pwm_reg, pwm_next;
    logic                cycle_start_reg;

    logic                boundary;
    logic [CTR_LEN-1:0]  period_eff;
    logic                center_eff;

    // A boundary is the enabled clock on which the counter sits at 0 heading
    // up. Idle and reset both park the counter there, so the first enabled
    // clock after either is automatically a boundary.
    assign boundary = enable && (cnt_reg == '0) && !dir_down_reg;

    // On the boundary clock the new cycle's settings already steer the step
    // out of 0 and the first output, so the new cycle is uniform from its
    // very first count.
    assign period_eff = boundary ? period : act_period_reg;
    assign center_eff = boundary ? center : act_center_reg;

    always_comb begin
        cnt_next      = cnt_reg;
        dir_down_next = dir_down_reg;
        if (!enable) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
        end else if (dir_down_reg) begin
            cnt_next      = cnt_reg - CTR_LEN'(1);
            // Reaching 0 on the way down turns the counter around; 0 is not
            // repeated because that clock is the next boundary.
            dir_down_next = (cnt_next != '0);
        end else if (cnt_reg >= period_eff) begin
            if (center_eff && (period_eff != '0)) begin
                // Top reached: step down immediately so the peak is not repeated.
                cnt_next      = cnt_reg - CTR_LEN'(1);
                dir_down_next = (cnt_next != '0);
            end else begin
                cnt_next      = '0;
                dir_down_next = 1'b0;
            end
        end else begin
            cnt_next = cnt_reg + CTR_LEN'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CTR_LEN-1:0] shadow_reg;
            logic [CTR_LEN-1:0] active_reg;
            logic [CTR_LEN-1:0] cmp_eff;

            // Active takes the shadow as it was before any same-clock write.
            assign cmp_eff     = boundary ? shadow_reg : active_reg;
            assign pwm_next[gi] = enable && (cmp_eff > cnt_reg);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (boundary)
                        active_reg <= shadow_reg;
                    if (wr_en && (wr_ch == CH_W'(gi)))
                        shadow_reg <= wr_compare;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            dir_down_reg    <= 1'b0;
            act_period_reg  <= '0;
            act_center_reg  <= 1'b0;
            pwm_reg         <= '0;
            cycle_start_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            dir_down_reg    <= dir_down_next;
            pwm_reg         <= pwm_next;
            cycle_start_reg <= boundary;
            if (boundary) begin
                act_period_reg <= period;
                act_center_reg <= center;
            end
        end
    end

    assign pwm         = pwm_reg;
    assign cycle_start = cycle_start_reg;

endmodule

// File: tb/tb_pwm_multi.sv
`timescale 1ns/100ps
// tb_pwm_multi
// Scoreboard bench for pwm_multi (CTR_LEN=8, CHANNELS=4, CH_W=3). The driver
// applies inputs on the falling edge, advances a cycle-position reference
// model and queues the expected {pwm, cycle_start}; a monitor pops and
// compares just after each rising edge.
module tb_pwm_multi;

    localparam int CTR_LEN  = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                center = 1'b0;
    logic [CTR_LEN-1:0]  period = '0;
    logic                wr_en = 1'b0;
    logic [CH_W-1:0]     wr_ch = '0;
    logic [CTR_LEN-1:0]  wr_compare = '0;
    logic [CHANNELS-1:0] pwm;
    logic                cycle_start;

    int total = 0;
    int bad   = 0;

    logic [CHANNELS:0] exp_q[$];

    // Reference model: position k within the current PWM cycle.
    int m_k = 0;
    int m_p = 0;
    bit m_center = 1'b0;
    int m_act[CHANNELS];
    int m_shadow[CHANNELS];

    pwm_multi #(.CTR_LEN(CTR_LEN), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .center(center),
        .period(period), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_compare(wr_compare), .pwm(pwm), .cycle_start(cycle_start)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_k = 0;
        m_p = 0;
        m_center = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_act[i] = 0;
            m_shadow[i] = 0;
        end
    endtask

    task automatic drive(input bit en, input bit ctr, input int per,
                         input bit we, input int ch, input int val);
        logic [CHANNELS:0] e;
        int len;
        int c;
        @(negedge clk);
        enable     = en;
        center     = ctr;
        period     = per[CTR_LEN-1:0];
        wr_en      = we;
        wr_ch      = ch[CH_W-1:0];
        wr_compare = val[CTR_LEN-1:0];
        e = '0;
        if (!en) begin
            m_k = 0;
        end else begin
            if (m_k == 0) begin
                m_p = per;
                m_center = ctr;
                for (int i = 0; i < CHANNELS; i++) m_act[i] = m_shadow[i];
            end
            if (m_p == 0)     len = 1;
            else if (m_center) len = 2 * m_p;
            else              len = m_p + 1;
            if (m_center && m_k > m_p) c = 2 * m_p - m_k;
            else                       c = m_k;
            for (int i = 0; i < CHANNELS; i++) e[i+1] = (m_act[i] > c);
            e[0] = (m_k == 0);
            m_k = (m_k + 1) % len;
        end
        if (we && ch < CHANNELS) m_shadow[ch] = val;
        exp_q.push_back(e);
        if (we) $display("write ch=%0d val=%0d en=%0b k_next=%0d", ch, val, en, m_k);
    endtask

    task automatic run(input int n, input bit ctr, input int per);
        for (int i = 0; i < n; i++) drive(1'b1, ctr, per, 1'b0, 0, 0);
    endtask

    // Monitor: one comparison per clocked output.
    initial begin
        logic [CHANNELS:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({pwm, cycle_start} !== e)
                    $display("FAIL out t=%0t pwm=%b cs=%b need pwm=%b cs=%b",
                             $time, pwm, cycle_start, e[CHANNELS:1], e[0]);
                if ({pwm, cycle_start} !== e) bad++;
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (pwm !== '0 || cycle_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_state pwm=%b cs=%b need 0/0", pwm, cycle_start);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Edge mode, period 9, ch0 = 3.
        drive(1'b0, 1'b0, 9, 1'b1, 0, 3);
        run(40, 1'b0, 9);

        // Center mode, period 4, ch1 = 2.
        drive(1'b1, 1'b1, 4, 1'b1, 1, 2);
        run(40, 1'b1, 4);

        // Shadow timing: ch2=5 mid-cycle, then ch2=7 on the boundary clock.
        run(3, 1'b0, 9);
        while (m_k != 5) drive(1'b1, 1'b0, 9, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 9, 1'b1, 2, 5);
        while (m_k != 0) drive(1'b1, 1'b0, 9, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 9, 1'b1, 2, 7);
        run(25, 1'b0, 9);

        // Extremes, and an out-of-range channel write.
        drive(1'b1, 1'b0, 99, 1'b1, 0, 0);
        drive(1'b1, 1'b0, 99, 1'b1, 3, 200);
        drive(1'b1, 1'b0, 99, 1'b1, 5, 50);
        run(220, 1'b0, 99);

        // Asynchronous reset pulse between edges while running.
        drive(1'b1, 1'b0, 9, 1'b1, 0, 6);
        run(25, 1'b0, 9);
        @(posedge clk);
        #1.5;
        rst_n = 1'b0;
        #1;
        total++;
        if (pwm !== '0 || cycle_start !== 1'b0) begin
            bad++;
            $display("FAIL async_reset pwm=%b cs=%b need 0/0", pwm, cycle_start);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        run(22, 1'b0, 9);

        // Enable dropped mid-cycle for 5 clocks.
        drive(1'b1, 1'b0, 9, 1'b1, 1, 4);
        run(14, 1'b0, 9);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 9, 1'b0, 0, 0);
        run(20, 1'b0, 9);

        // Period 0 and full-range period in both modes.
        run(6, 1'b0, 0);
        run(6, 1'b1, 0);
        drive(1'b1, 1'b1, 255, 1'b1, 2, 128);
        run(520, 1'b1, 255);

        // Randomized traffic.
        begin
            bit en_r = 1'b1;
            bit c_r = 1'b0;
            int p_r = 5;
            for (int i = 0; i < 1500; i++) begin
                bit we;
                if ($urandom_range(0, 40) == 0) c_r = ~c_r;
                if ($urandom_range(0, 30) == 0) p_r = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 12);
                if ($urandom_range(0, 60) == 0) en_r = ~en_r;
                if (!en_r && $urandom_range(0, 4) == 0) en_r = 1'b1;
                we = ($urandom_range(0, 9) == 0);
                drive(en_r, c_r, p_r, we, $urandom_range(0, 7), $urandom_range(0, 15));
            end
        end

        drive(1'b0, 1'b0, 0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain left=%0d need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
